// File: rtl/vpu_seq_controller.sv
// rtl/vpu_seq_controller.sv - vector instruction sequencer: operand fetch, multi-pass exec, writeback, response
module vpu_seq_controller #(
  parameter int SRC_CNT        = 3,
  parameter int MAX_PASSES     = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PASS_W        = $clog2(MAX_PASSES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_valid_i,
  output logic              ctrl_ready_o,
  input  logic [SRC_CNT-1:0] instr_rvalid_i,
  input  logic [PASS_W-1:0] instr_pass_cnt_i,
  input  logic              instr_wb_en_i,
  output logic              opget_start_o,
  input  logic              opget_done_i,
  output logic [SRC_CNT-1:0] operand_queue_rden_o,
  output logic              exec_start_o,
  input  logic              exec_done_i,
  output logic [PASS_W-1:0] exec_pass_idx_o,
  output logic              wb_data_valid_o,
  output logic              wb_start_o,
  input  logic              wb_done_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_error_o,
  output logic              busy_o
);

  // Watchdog width covers 0..TIMEOUT_CYCLES-1; a zero limit disables expiry entirely.
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GETOP,
    S_EXEC,
    S_WB,
    S_RSP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SRC_CNT-1:0]  r_rvalid;
  logic [PASS_W-1:0]   r_passes;
  logic                r_wb_en;
  logic [PASS_W-1:0]   r_pass_idx;
  logic [WD_W-1:0]     r_wdog;
  logic                r_err;
  logic                r_opget_start;

  logic                w_accept;
  logic                w_timeout;
  logic                w_done_evt;
  logic                w_to_err;
  logic                w_idx_clear;
  logic                w_idx_inc;
  logic                w_more;
  logic [PASS_W-1:0]   w_pass_inc;
  logic [PASS_W-1:0]   w_passes_in;

  assign w_accept      = ctrl_valid_i & ctrl_ready_o;
  assign w_timeout     = (TIMEOUT_CYCLES != 0) && (r_wdog == WD_LIMIT);
  assign w_pass_inc    = r_pass_idx + PASS_W'(1);
  assign w_more        = (w_pass_inc < r_passes);
  assign busy_o        = (r_state != S_IDLE);
  assign opget_start_o = r_opget_start;

  // Requested pass count: zero means one pass, anything above the maximum is clamped.
  always_comb begin
    w_passes_in = instr_pass_cnt_i;
    if (instr_pass_cnt_i == '0) begin
      w_passes_in = PASS_W'(1);
    end else if (instr_pass_cnt_i > PASS_W'(MAX_PASSES)) begin
      w_passes_in = PASS_W'(MAX_PASSES);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all handshake/pulse outputs; an expected done always beats watchdog expiry.
  always_comb begin
    w_state_nxt          = r_state;
    ctrl_ready_o         = 1'b0;
    exec_start_o         = 1'b0;
    operand_queue_rden_o = '0;
    exec_pass_idx_o      = '0;
    wb_data_valid_o      = 1'b0;
    wb_start_o           = 1'b0;
    rsp_valid_o          = 1'b0;
    rsp_error_o          = 1'b0;
    w_done_evt           = 1'b0;
    w_to_err             = 1'b0;
    w_idx_clear          = 1'b0;
    w_idx_inc            = 1'b0;
    case (r_state)
      S_IDLE: begin
        ctrl_ready_o = 1'b1;
        if (ctrl_valid_i) begin
          w_state_nxt = S_GETOP;
        end
      end
      S_GETOP: begin
        if (opget_done_i) begin
          w_done_evt           = 1'b1;
          exec_start_o         = 1'b1;
          operand_queue_rden_o = r_rvalid;
          w_idx_clear          = 1'b1;
          w_state_nxt          = S_EXEC;
        end else if (w_timeout) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          w_done_evt      = 1'b1;
          wb_data_valid_o = r_wb_en;
          if (w_more) begin
            w_idx_inc            = 1'b1;
            exec_start_o         = 1'b1;
            operand_queue_rden_o = r_rvalid;
            exec_pass_idx_o      = w_pass_inc;
          end else if (r_wb_en) begin
            wb_start_o  = 1'b1;
            w_state_nxt = S_WB;
          end else begin
            w_state_nxt = S_RSP;
          end
        end else if (w_timeout) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_WB: begin
        if (wb_done_i) begin
          w_done_evt  = 1'b1;
          w_state_nxt = S_RSP;
        end else if (w_timeout) begin
          w_to_err    = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        rsp_valid_o = 1'b1;
        rsp_error_o = r_err;
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Instruction fields captured at acceptance, pass index, fetch-start pulse and response error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid      <= '0;
      r_passes      <= '0;
      r_wb_en       <= 1'b0;
      r_pass_idx    <= '0;
      r_err         <= 1'b0;
      r_opget_start <= 1'b0;
    end else begin
      r_opget_start <= w_accept;
      if (w_accept) begin
        r_rvalid <= instr_rvalid_i;
        r_passes <= w_passes_in;
        r_wb_en  <= instr_wb_en_i;
      end
      if (w_idx_clear) begin
        r_pass_idx <= '0;
      end else if (w_idx_inc) begin
        r_pass_idx <= w_pass_inc;
      end
      if ((w_state_nxt == S_RSP) && (r_state != S_RSP)) begin
        r_err <= w_to_err;
      end
    end
  end

  // Watchdog: restarts on every state change and every expected done; idle outside the waiting states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if ((w_state_nxt != r_state) || w_done_evt ||
                 (r_state == S_IDLE) || (r_state == S_RSP)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

endmodule

// File: doc/vpu_seq_controller.md
VPU_SEQ_CONTROLLER -- requirements
Module: vpu_seq_controller

Interface
REQ-001 SHALL have parameter SRC_CNT, default 3, the number of source operand queues.
REQ-002 SHALL have parameter MAX_PASSES, default 4, the maximum number of EXEC passes per instruction; PASS_W = $clog2(MAX_PASSES+1).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit per substate; 0 disables the watchdog.
REQ-004 SHALL have ports clk in 1 (clock) and rst in 1 (reset, synchronous, active-high).
REQ-005 SHALL have ports ctrl_valid_i in 1 and ctrl_ready_o out 1: instruction handshake.
REQ-006 SHALL have ports instr_rvalid_i in SRC_CNT (operand queues used), instr_pass_cnt_i in PASS_W (EXEC passes requested) and instr_wb_en_i in 1 (writeback required).
REQ-007 SHALL have ports opget_start_o out 1 and opget_done_i in 1.
REQ-008 SHALL have port operand_queue_rden_o out SRC_CNT: per-queue pop strobe.
REQ-009 SHALL have ports exec_start_o out 1, exec_done_i in 1 and exec_pass_idx_o out PASS_W.
REQ-010 SHALL have ports wb_data_valid_o out 1, wb_start_o out 1 and wb_done_i in 1.
REQ-011 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_error_o out 1 and busy_o out 1.

Function
REQ-012 SHALL implement the states IDLE, GETOP, EXEC, WB and RSP; busy_o = (state != IDLE).
REQ-013 IDLE: ctrl_ready_o = 1; all other states: ctrl_ready_o = 0.
REQ-014 On ctrl_valid_i & ctrl_ready_o, SHALL latch rvalid, pass count (0 saturates to 1; values >MAX_PASSES clamp to MAX_PASSES) and wb_en, then go to GETOP; later changes on instr_* inputs SHALL be ignored.
REQ-015 opget_start_o SHALL be a registered one-cycle pulse in the cycle after acceptance.
REQ-016 GETOP, on opget_done_i: SHALL assert exec_start_o and operand_queue_rden_o = latched rvalid for that cycle (combinational), clear pass_idx to 0 and go to EXEC.
REQ-017 EXEC, on exec_done_i with pass_idx < passes-1: SHALL increment pass_idx, assert exec_start_o and rden = latched rvalid (same cycle), and stay in EXEC.
REQ-018 EXEC, on exec_done_i on the last pass: SHALL assert no rden; if wb_en, assert wb_start_o and go to WB, else go to RSP.
REQ-019 wb_data_valid_o SHALL pulse with every exec_done_i in EXEC when wb_en = 1, and SHALL never assert when wb_en = 0.
REQ-020 exec_pass_idx_o SHALL equal the index of the pass being started whenever exec_start_o = 1: 0 from GETOP, pass_idx+1 on an intermediate done.
REQ-021 WB, on wb_done_i: SHALL go to RSP with error = 0.
REQ-022 RSP: rsp_valid_o = 1 and rsp_error_o held stable until rsp_ready_i; on the handshake SHALL go to IDLE; the next instruction SHALL be accepted no earlier than the following cycle.
REQ-023 Watchdog: the counter SHALL clear on state entry and on each done; if it reaches TIMEOUT_CYCLES-1 in GETOP/EXEC/WB without the expected done, the block SHALL go to RSP with error = 1 and assert no start or rden.
REQ-024 A done and watchdog expiry in the same cycle: done SHALL win.
REQ-025 Done inputs not expected in the current state SHALL be ignored and SHALL NOT produce side effects.
REQ-026 All start, rden and wb_data_valid outputs SHALL be single-cycle pulses per event, never held.

Reset
REQ-027 rst = 1 at a clock edge SHALL force IDLE, pass_idx = 0, the watchdog counter to 0, all latched fields to 0 and opget_start_o = 0; all outputs are 0 except ctrl_ready_o = 1.
REQ-028 Reset mid-operation SHALL abandon the instruction with no response; done pulses after reset SHALL be ignored.

Verification
REQ-029 SRC_CNT=3, rvalid=3'b101, passes=2, wb_en=1, dones after 1 cycle each -> opget_start 1 cycle after accept; rden=101 twice; exec_pass_idx 0 then 1; wb_data_valid twice; wb_start once; rsp_valid with error=0.
REQ-030 passes=0, wb_en=0 -> exactly one exec_start; no wb_start; no wb_data_valid; RSP reached directly after exec_done.
REQ-031 TIMEOUT_CYCLES=8, exec_done withheld -> RSP with error=1 8 cycles after EXEC entry; exec_done arriving in the expiry cycle -> error=0 and normal progress.
REQ-032 rsp_ready_i held low 5 cycles -> rsp_valid and rsp_error stable; ctrl_ready_o=0 throughout; ctrl_ready_o=1 the cycle after the handshake.
REQ-033 rst in EXEC on pass 1 of 3 -> IDLE next cycle, all outputs 0, ctrl_ready_o=1; a stray exec_done is ignored.
REQ-034 instr_* inputs changed after accept, and opget_done pulsed while in EXEC -> latched behaviour unchanged; no extra pulses.
